im_loader: RTL and testbench

Boot-time configurer for the writable instruction memory (32 x 32-bit words, word-addressed by PC[31:2]). It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word to consecutive IM addresses starting at 0. The CPU core is held in hold (cpu_hold) until the requested number of words has been written, then released to fetch from address 0.

---
 rtl/im_pkg.sv | 15 +
 rtl/im_loader_if.sv | 9 +
 rtl/im_word_assembler.sv | 30 +++
 rtl/im_loader.sv | 98 +++++++++
 tb/tb_im_loader.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/im_pkg.sv
// Shared constants and types for the instruction-memory loader slice.
package im_pkg;
  localparam int          IM_DEPTH  = 32;
  localparam int          IM_ADDR_W = 5;
  localparam int          INST_W    = 32;
  // addi x0,x0,0 -- used by whoever pre-fills the IM before a load
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_e;
endpackage

// File: rtl/im_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface im_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);
endinterface

// File: rtl/im_word_assembler.sv
// Collects four stream bytes into one little-endian instruction word.
module im_word_assembler
  import im_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [7:0]        byte_i,
  output logic [INST_W-1:0] word_o,
  output logic              word_full_o
);
  logic [1:0]        bcnt_q;
  logic [INST_W-1:0] word_q;

  // Byte position counter; wraps 3->0 so the next word starts at lane 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) bcnt_q <= 2'd0;
    else if (load_i)     bcnt_q <= bcnt_q + 2'd1;
  end

  // Insert the accepted byte into its lane; the word stays stable otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n)      word_q <= '0;
    else if (load_i) word_q[{bcnt_q, 3'b000} +: 8] <= byte_i;
  end

  assign word_o      = word_q;
  assign word_full_o = load_i && (bcnt_q == 2'd3);
endmodule

// File: rtl/im_loader.sv
// Boot-time IM loader: streams bytes into words, writes them from address 0,
// and holds the core until the requested word count is in memory.
module im_loader
  import im_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DEPTH  = IM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   n_words,
  im_loader_if.slave        bs,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [INST_W-1:0] wdata_o,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   n_q, wcnt_q, wcnt_inc;
  logic [ADDR_W-1:0] waddr_q;
  logic              err_q, hold_q;
  logic              legal, idle_or_done, start_ok, start_bad;
  logic              accept, word_full;

  assign legal        = (n_words != '0) && (n_words <= DEPTH_W);
  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign start_ok     = start && legal && idle_or_done;
  assign start_bad    = start && !legal && idle_or_done;
  assign accept       = bs.byte_valid && bs.byte_ready;
  // Counter is one bit wider than the address so n_words=DEPTH never wraps.
  assign wcnt_inc     = wcnt_q + ONE_W;

  im_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start_ok),
    .load_i      (accept),
    .byte_i      (bs.byte_data),
    .word_o      (wdata_o),
    .word_full_o (word_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_ok)  state_d = LOAD;
      LOAD:       if (word_full) state_d = WRITE;
      WRITE:      state_d = (wcnt_inc == n_q) ? DONE : LOAD;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; write strobe is suppressed while reset is held.
  always_comb begin
    bs.byte_ready = (state_q == LOAD);
    we_o          = (state_q == WRITE) && rst_n;
    done          = (state_q == DONE);
  end

  // Datapath registers: word count, write address, error flag and core hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q     <= '0;
      wcnt_q  <= '0;
      waddr_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      hold_q <= (state_d != DONE);
      if (start_ok) begin
        n_q    <= n_words;
        wcnt_q <= '0;
        err_q  <= 1'b0;
      end else if (start_bad) begin
        err_q  <= 1'b1;
      end
      if (state_q == WRITE) wcnt_q  <= wcnt_inc;
      if (state_d == WRITE) waddr_q <= wcnt_q[ADDR_W-1:0];
    end
  end

  assign waddr_o  = waddr_q;
  assign cpu_hold = hold_q;
  assign err      = err_q;
endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader.
module tb_im_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  n_words = '0;
  logic        we_o, cpu_hold, done, err;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [4:0]  la[$];
  logic [31:0] ld[$];

  im_loader_if bif();

  im_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_words(n_words), .bs(bif),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Log every IM write strobe mid-cycle.
  always @(negedge clk) if (we_o === 1'b1) begin la.push_back(waddr_o); ld.push_back(wdata_o); end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    bif.byte_valid = 1'b1; bif.byte_data = b;
    while (bif.byte_ready !== 1'b1 && w < 20) begin tick(); w++; end
    n_chk++;
    if (w >= 20) begin n_fail++; $display("FAIL send_byte: byte_ready never rose for %h", b); end
    else tick();
  endtask

  task automatic wait_done(input int limit);
    int w = 0;
    while (done !== 1'b1 && w < limit) begin tick(); w++; end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL wait_done: done=%b after %0d cycles", done, w); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; bif.byte_valid = 1'b0; bif.byte_data = '0;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b exp 1", cpu_hold); end
    n_chk++; if ({done, err, we_o, bif.byte_ready} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {done, err, we_o, bif.byte_ready}); end
    n_chk++; if (waddr_o !== 5'd0 || wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_bus: got %h/%h exp 0/0", waddr_o, wdata_o); end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_two_words();
    la.delete(); ld.delete();
    start = 1'b1; n_words = 6'd2; tick(); start = 1'b0;
    send_byte(8'h13); send_byte(8'h04); send_byte(8'h30); send_byte(8'h00);
    n_chk++; if (we_o !== 1'b1 || waddr_o !== 5'd0 || wdata_o !== 32'h00300413) begin n_fail++; $display("FAIL tw_word0: got we=%b a=%0d d=%h exp 1/0/00300413", we_o, waddr_o, wdata_o); end
    send_byte(8'h93); send_byte(8'h04); send_byte(8'h10); send_byte(8'h00);
    n_chk++; if (we_o !== 1'b1 || waddr_o !== 5'd1 || wdata_o !== 32'h00100493) begin n_fail++; $display("FAIL tw_word1: got we=%b a=%0d d=%h exp 1/1/00100493", we_o, waddr_o, wdata_o); end
    n_chk++; if (bif.byte_ready !== 1'b0) begin n_fail++; $display("FAIL tw_ready_in_write: got %b exp 0", bif.byte_ready); end
    bif.byte_valid = 1'b0; tick();
    n_chk++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL tw_done: got done=%b hold=%b exp 1/0", done, cpu_hold); end
    n_chk++; if (la.size() !== 2) begin n_fail++; $display("FAIL tw_count: got %0d exp 2", la.size()); end
  endtask

  task automatic test_full_depth();
    logic [7:0] b[128];
    logic [31:0] exp_w;
    for (int j = 0; j < 128; j++) b[j] = 8'((j * 37 + 5) & 255);
    la.delete(); ld.delete();
    start = 1'b1; n_words = 6'd32; tick(); start = 1'b0;
    n_chk++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL fd_reload_hold: got hold=%b done=%b exp 1/0", cpu_hold, done); end
    for (int j = 0; j < 128; j++) begin
      bif.byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      send_byte(b[j]);
    end
    bif.byte_valid = 1'b0;
    wait_done(20);
    repeat (3) tick();
    n_chk++; if (la.size() !== 32) begin n_fail++; $display("FAIL fd_count: got %0d exp 32", la.size()); end
    for (int i = 0; i < 32 && i < la.size(); i++) begin
      exp_w = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
      n_chk++; if (la[i] !== 5'(i) || ld[i] !== exp_w) begin n_fail++; $display("FAIL fd_word%0d: got a=%0d d=%h exp a=%0d d=%h", i, la[i], ld[i], i, exp_w); end
    end
  endtask

  task automatic test_illegal_start();
    do_reset(); rst_n = 1'b1; tick();
    la.delete(); ld.delete();
    bif.byte_valid = 1'b1; bif.byte_data = 8'h55;
    start = 1'b1; n_words = 6'd0; tick();
    n_chk++; if (err !== 1'b1 || cpu_hold !== 1'b1 || bif.byte_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL il_zero: got err=%b hold=%b rdy=%b done=%b exp 1/1/0/0", err, cpu_hold, bif.byte_ready, done); end
    n_words = 6'd33; tick(); start = 1'b0;
    n_chk++; if (err !== 1'b1 || bif.byte_ready !== 1'b0) begin n_fail++; $display("FAIL il_33: got err=%b rdy=%b exp 1/0", err, bif.byte_ready); end
    repeat (3) tick();
    n_chk++; if (la.size() !== 0 || bif.byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL il_idle: got writes=%0d rdy=%b hold=%b exp 0/0/1", la.size(), bif.byte_ready, cpu_hold); end
    bif.byte_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    la.delete(); ld.delete();
    start = 1'b1; n_words = 6'd2; tick(); start = 1'b0;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL mr_err_clear: got %b exp 0", err); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    bif.byte_valid = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (3) tick();
    n_chk++; if (la.size() !== 1 || cpu_hold !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL mr_after: got writes=%0d hold=%b done=%b exp 1/1/0", la.size(), cpu_hold, done); end
    n_chk++; if (la.size() > 0 && ld[0] !== 32'h44332211) begin n_fail++; $display("FAIL mr_word0: got %h exp 44332211", ld[0]); end
    start = 1'b1; n_words = 6'd1; tick(); start = 1'b0;
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    bif.byte_valid = 1'b0;
    wait_done(5);
    n_chk++; if (la.size() !== 2 || la[la.size()-1] !== 5'd0 || ld[ld.size()-1] !== 32'hD4C3B2A1) begin n_fail++; $display("FAIL mr_reload: got n=%0d a=%0d d=%h exp 2/0/d4c3b2a1", la.size(), la[la.size()-1], ld[ld.size()-1]); end
  endtask

  task automatic test_reload_from_done();
    la.delete(); ld.delete();
    bif.byte_valid = 1'b1; bif.byte_data = 8'h33;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (bif.byte_ready !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL rd_done_ready%0d: got rdy=%b done=%b exp 0/1", k, bif.byte_ready, done); end
    end
    start = 1'b1; n_words = 6'd1; tick();
    n_chk++; if (cpu_hold !== 1'b1 || done !== 1'b0 || bif.byte_ready !== 1'b1) begin n_fail++; $display("FAIL rd_start_edge: got hold=%b done=%b rdy=%b exp 1/0/1", cpu_hold, done, bif.byte_ready); end
    send_byte(8'h33); send_byte(8'h05); send_byte(8'h94); send_byte(8'h00);
    n_chk++; if (we_o !== 1'b1 || waddr_o !== 5'd0 || wdata_o !== 32'h00940533) begin n_fail++; $display("FAIL rd_write: got we=%b a=%0d d=%h exp 1/0/00940533", we_o, waddr_o, wdata_o); end
    start = 1'b0; bif.byte_valid = 1'b0; tick();
    n_chk++; if (done !== 1'b1 || cpu_hold !== 1'b0 || la.size() !== 1) begin n_fail++; $display("FAIL rd_done: got done=%b hold=%b writes=%0d exp 1/0/1", done, cpu_hold, la.size()); end
    start = 1'b1; n_words = 6'd40; tick(); start = 1'b0;
    n_chk++; if (err !== 1'b1 || done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL rd_bad_start: got err=%b done=%b hold=%b exp 1/1/0", err, done, cpu_hold); end
  endtask

  task automatic test_back_to_back();
    la.delete(); ld.delete();
    start = 1'b1; n_words = 6'd2; tick(); start = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    bif.byte_data = 8'hAA;
    n_chk++; if (bif.byte_ready !== 1'b0 || we_o !== 1'b1) begin n_fail++; $display("FAIL bb_write: got rdy=%b we=%b exp 0/1", bif.byte_ready, we_o); end
    tick();
    n_chk++; if (bif.byte_ready !== 1'b1 || we_o !== 1'b0) begin n_fail++; $display("FAIL bb_load: got rdy=%b we=%b exp 1/0", bif.byte_ready, we_o); end
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    n_chk++; if (waddr_o !== 5'd1 || wdata_o !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL bb_word1: got a=%0d d=%h exp 1/ddccbbaa", waddr_o, wdata_o); end
    bif.byte_valid = 1'b0;
    wait_done(5);
    n_chk++; if (la.size() !== 2 || ld[0] !== 32'h04030201) begin n_fail++; $display("FAIL bb_log: got n=%0d d0=%h exp 2/04030201", la.size(), ld[0]); end
  endtask

  initial begin
    bif.byte_valid = 1'b0; bif.byte_data = '0;
    test_reset();
    test_two_words();
    test_full_depth();
    test_illegal_start();
    test_mid_reset();
    test_reload_from_done();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
